// File: rtl/vga_pixel_write_ctrl_if.sv
// ---------------------------------------------------------------------------
// vga_pixel_write_ctrl_if : Avalon-MM register port plus frame-buffer write port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface vga_pixel_write_ctrl_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  logic              vga_we;
  logic              vga_ready;

  modport slave (
    input  address, chipselect, write_n, writedata, vga_ready,
    output readdata, vga_addr, vga_data, vga_we
  );

  modport master (
    output address, chipselect, write_n, writedata, vga_ready,
    input  readdata, vga_addr, vga_data, vga_we
  );
endinterface

`default_nettype wire

// File: rtl/vga_pixel_write_ctrl.sv
// ---------------------------------------------------------------------------
// vga_pixel_write_ctrl : HPS pixel writes via command FIFO; fill engine under VGA_FILL_EN
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_pixel_write_ctrl #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  vga_pixel_write_ctrl_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  localparam logic [1:0] REG_ADDR = 2'd0;
  localparam logic [1:0] REG_DATA = 2'd1;
  localparam logic [1:0] REG_FILL = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

`ifdef VGA_FILL_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_FILL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1} state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
  logic [DATA_W-1:0] colour_q, colour_d;
  logic              ovf_q, ovf_d;
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  level_q, level_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
`ifdef VGA_FILL_EN
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic              fill_go;
`endif

  logic wr_en, fifo_full, fifo_empty, busy, push, pop, we, accept;
  logic [31:0] status;
  logic unused_wdata;

  assign wr_en      = bus.chipselect && !bus.write_n;
  assign fifo_full  = (level_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign push       = wr_en && (bus.address == REG_DATA) && !fifo_full;
  assign we         = (state_q != ST_IDLE);
  assign accept     = we && bus.vga_ready;

  assign bus.vga_we   = we;
  assign bus.vga_addr = out_addr_q;
  assign bus.vga_data = out_data_q;

  assign unused_wdata = ^bus.writedata[31:ADDR_W];

`ifdef VGA_FILL_EN
  assign fill_go = wr_en && (bus.address == REG_FILL) && !busy
                   && (bus.writedata[ADDR_W-1:0] != '0);
`endif

  // Register file: a dropped push leaves address and colour untouched
  always_comb begin
    pixel_addr_d = pixel_addr_q;
    colour_d     = colour_q;
    ovf_d        = ovf_q;
    if (wr_en) begin
      case (bus.address)
        REG_ADDR: pixel_addr_d = bus.writedata[ADDR_W-1:0];
        REG_DATA: begin
          if (fifo_full) begin
            ovf_d = 1'b1;
          end else begin
            pixel_addr_d = pixel_addr_q + ADDR_W'(1);
            colour_d     = bus.writedata[DATA_W-1:0];
          end
        end
`ifdef VGA_FILL_EN
        REG_FILL: if (busy) ovf_d = 1'b1;
`endif
        REG_STAT: if (bus.writedata[3]) ovf_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + CNT_W'(1);
      2'b01:   level_d = level_q - CNT_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
`ifdef VGA_FILL_EN
    fill_cnt_d = fill_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop                      = 1'b1;
          {out_addr_d, out_data_d} = mem_q[rd_ptr_q];
          state_d                  = ST_ISSUE;
        end
`ifdef VGA_FILL_EN
        else if (fill_go) begin
          out_addr_d = pixel_addr_q;
          out_data_d = colour_q;
          fill_cnt_d = bus.writedata[ADDR_W-1:0];
          state_d    = ST_FILL;
        end
`endif
      end
      ST_ISSUE: begin
        // Reload on the accepting edge so back-to-back entries have no bubble
        if (accept) begin
          if (!fifo_empty) begin
            pop                      = 1'b1;
            {out_addr_d, out_data_d} = mem_q[rd_ptr_q];
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
`ifdef VGA_FILL_EN
      ST_FILL: begin
        if (accept) begin
          out_addr_d = out_addr_q + ADDR_W'(1);
          fill_cnt_d = fill_cnt_q - ADDR_W'(1);
          if (fill_cnt_q == ADDR_W'(1)) state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    status             = '0;
    status[0]          = busy;
    status[1]          = fifo_full;
    status[2]          = fifo_empty;
    status[3]          = ovf_q;
    status[8 +: CNT_W] = level_q;
    bus.readdata       = '0;
    case (bus.address)
      REG_ADDR: bus.readdata[ADDR_W-1:0] = pixel_addr_q;
      REG_DATA: bus.readdata[DATA_W-1:0] = colour_q;
      REG_STAT: bus.readdata             = status;
      default:  bus.readdata             = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pixel_addr_q <= '0;
      colour_q     <= '0;
      ovf_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
`ifdef VGA_FILL_EN
      fill_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pixel_addr_q <= pixel_addr_d;
      colour_q     <= colour_d;
      ovf_q        <= ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
`ifdef VGA_FILL_EN
      fill_cnt_q   <= fill_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pixel_addr_q, bus.writedata[DATA_W-1:0]};
  end

endmodule

`default_nettype wire
